// File: rtl/ram_read_demux.sv
// ram_read_demux: single-entry holding stage that steers each RAM read word
// to either the system port (out0) or the BIST port (out1). The destination
// is latched together with the word, so later select changes only affect
// subsequent words. Per-port delivered-word counters saturate at all-ones.
module ram_read_demux #(
    parameter int WIDTH = 9,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1,
    output logic             busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             in_xfer;
    logic             out0_xfer;
    logic             out1_xfer;

    // Counter increment that sticks at the maximum value instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Handshake decode: the held word may leave whenever its own port is
    // ready, which also frees the register for a same-cycle reload.
    always_comb begin
        out0_xfer = (state == HOLD0) && out0_ready;
        out1_xfer = (state == HOLD1) && out1_ready;
        in_ready  = rst_n && ((state == EMPTY) || out0_xfer || out1_xfer);
        in_xfer   = in_valid && in_ready;
    end

    // Output decode straight from registered state; valids never see the readies.
    always_comb begin
        out0_valid = (state == HOLD0);
        out1_valid = (state == HOLD1);
        out0_data  = out0_valid ? hold : '0;
        out1_data  = out1_valid ? hold : '0;
        busy       = (state != EMPTY);
    end

    // Holding FSM and delivered-word counters; reset drops any held word uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            hold   <= '0;
            count0 <= '0;
            count1 <= '0;
        end else begin
            if (in_xfer) begin
                hold  <= in_data;
                state <= select ? HOLD1 : HOLD0;
            end else if (out0_xfer || out1_xfer) begin
                state <= EMPTY;
            end
            if (out0_xfer) begin
                count0 <= sat_inc(count0);
            end
            if (out1_xfer) begin
                count1 <= sat_inc(count1);
            end
        end
    end

endmodule

// File: tb/tb_ram_read_demux.sv
// Testbench for ram_read_demux: directed scenarios followed by random traffic,
// checked against a one-entry transaction model. A second instance with a
// 4-bit counter shares the same stimulus to exercise counter saturation.
module tb_ram_read_demux;

    logic       clk;
    logic       rst_n;
    logic [8:0] in_data;
    logic       in_valid;
    logic       select;
    logic       out0_ready;
    logic       out1_ready;

    logic       in_ready,  out0_valid,  out1_valid,  busy;
    logic [8:0] out0_data, out1_data;
    logic [15:0] count0, count1;

    logic       in_ready4, out0_valid4, out1_valid4, busy4;
    logic [8:0] out0_data4, out1_data4;
    logic [3:0] count0_4, count1_4;

    int checks;
    int failures;

    // Reference model: at most one word in flight, tagged with its destination.
    bit         m_full;
    int         m_dest;
    logic [8:0] m_data;
    int         m_cnt0, m_cnt1;

    ram_read_demux #(.WIDTH(9), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .select(select),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .count0(count0), .count1(count1), .busy(busy)
    );

    ram_read_demux #(.WIDTH(9), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .select(select),
        .out0_data(out0_data4), .out0_valid(out0_valid4), .out0_ready(out0_ready),
        .out1_data(out1_data4), .out1_valid(out1_valid4), .out1_ready(out1_ready),
        .count0(count0_4), .count1(count1_4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0;
        m_dest = 0;
        m_data = '0;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    task automatic check_outputs();
        logic       e_rdy, e_v0, e_v1;
        logic [8:0] e_d0, e_d1;
        e_rdy = rst_n && (!m_full || (m_dest == 0 ? out0_ready : out1_ready));
        e_v0  = m_full && (m_dest == 0);
        e_v1  = m_full && (m_dest == 1);
        e_d0  = e_v0 ? m_data : 9'h000;
        e_d1  = e_v1 ? m_data : 9'h000;
        chk("in_ready",   {31'b0, in_ready},   {31'b0, e_rdy});
        chk("out0_valid", {31'b0, out0_valid}, {31'b0, e_v0});
        chk("out1_valid", {31'b0, out1_valid}, {31'b0, e_v1});
        chk("out0_data",  {23'b0, out0_data},  {23'b0, e_d0});
        chk("out1_data",  {23'b0, out1_data},  {23'b0, e_d1});
        chk("busy",       {31'b0, busy},       {31'b0, m_full});
        chk("count0",     {16'b0, count0},     (m_cnt0 > 65535) ? 32'd65535 : m_cnt0);
        chk("count1",     {16'b0, count1},     (m_cnt1 > 65535) ? 32'd65535 : m_cnt1);
        chk("cw4_count0", {28'b0, count0_4},   (m_cnt0 > 15) ? 32'd15 : m_cnt0);
        chk("cw4_count1", {28'b0, count1_4},   (m_cnt1 > 15) ? 32'd15 : m_cnt1);
        chk("cw4_in_ready", {31'b0, in_ready4}, {31'b0, e_rdy});
        chk("cw4_out0_valid", {31'b0, out0_valid4}, {31'b0, e_v0});
        chk("cw4_out1_data",  {23'b0, out1_data4},  {23'b0, e_d1});
    endtask

    // One clock cycle with the currently driven inputs: check, advance model, step.
    task automatic step();
        bit out_go, in_go;
        #1;
        check_outputs();
        out_go = m_full && (m_dest == 0 ? out0_ready : out1_ready);
        in_go  = in_valid && (!m_full || out_go);
        @(posedge clk);
        if (out_go) begin
            if (m_dest == 0) m_cnt0++;
            else             m_cnt1++;
        end
        if (in_go) begin
            m_full = 1;
            m_data = in_data;
            m_dest = select ? 1 : 0;
        end else if (out_go) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [8:0] d, input logic s,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_data    = d;
        select     = s;
        out0_ready = r0;
        out1_ready = r1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        select     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        model_reset();

        // Reset state
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single word to out0, ready immediately; accepted on first edge after reset
        drive(1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1);
        chk("req34_out0_valid", {31'b0, out0_valid}, 32'd1);
        chk("req34_out0_data",  {23'b0, out0_data},  32'h1FF);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        chk("req34_count0", {16'b0, count0}, 32'd1);
        chk("req34_count1", {16'b0, count1}, 32'd0);

        // Word to out1 with three stalled cycles
        drive(1'b1, 9'h100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9'h0F0, 1'b0, 1'b1, 1'b0);
            chk("req35_stall_data", {23'b0, out1_data}, 32'h100);
        end
        drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        chk("req35_count1", {16'b0, count1}, 32'd1);

        // Select flips while a word waits for out0; it must still leave on out0
        drive(1'b1, 9'h0AB, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        chk("req36_still_out0", {31'b0, out0_valid}, 32'd1);
        drive(1'b1, 9'h055, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        chk("req36_count0", {16'b0, count0}, 32'd2);
        chk("req36_count1", {16'b0, count1}, 32'd2);

        // Back-to-back words, select 0,1,1,0
        drive(1'b1, 9'h011, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 9'h122, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 9'h033, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 9'h144, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        chk("req37_count0", {16'b0, count0}, 32'd4);
        chk("req37_count1", {16'b0, count1}, 32'd4);

        // Seventeen more words to out0: the 4-bit counter pins at 15
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 9'(i * 29 + 3), 1'b0, 1'b1, 1'b1);
        end
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        chk("req38_cw4_count0", {28'b0, count0_4}, 32'd15);
        chk("req38_count0",     {16'b0, count0},   32'd21);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  9'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end

        // Reset while a word waits on a stalled out1
        drive(1'b1, 9'h1AA, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("req39_out1_valid", {31'b0, out1_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 9'h000, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b1, 1'b1, 1'b1);
        chk("req39_count1", {16'b0, count1}, 32'd0);
        drive(1'b1, 9'h07E, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
